// File: rtl/mux81_sched_pkg.sv
// Shared constants, state encoding and helpers for the
// round-robin mux81 scheduler.
package mux81_sched_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N_CH-1:0] onehot(
        input logic [SEL_W-1:0] sel
    );
        logic [N_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request bit after ptr,
// wrapping upward; ptr itself is checked last.
module rr_pick8
    import mux81_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic             w_hit;
    logic [SEL_W-1:0] w_c;

    always_comb begin
        found = |req;
        idx   = '0;
        w_hit = 1'b0;
        w_c   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_c = ptr + SEL_W'(k);
            if (!w_hit && req[w_c]) begin
                idx   = w_c;
                w_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin scheduler time-sharing one mux81_enable between
// 8 channels, with a one-clock disabled gap after every grant.
module mux81_rr_sched
    import mux81_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] s,
    output logic             e,
    output logic [N_CH-1:0]  gnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_s;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_e;
    logic [N_CH-1:0]  r_gnt;
    logic             r_busy;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_ptr   <= SEL_W'(N_CH - 1);
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, GAP: begin
                    // Both IDLE and GAP run a fresh search from ptr+1
                    if (w_found) begin
                        r_state <= GRANT;
                        r_s     <= w_idx;
                        r_ptr   <= w_idx;
                        r_cnt   <= '0;
                        r_e     <= 1'b0;
                        r_gnt   <= onehot(w_idx);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_e     <= 1'b1;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (r_cnt == LP_LAST || !req[r_s]) begin
                        r_state <= GAP;
                        r_e     <= 1'b1;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_e     <= 1'b1;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign e    = r_e;
    assign gnt  = r_gnt;
    assign busy = r_busy;

endmodule

// File: tb/tb_mux81_rr_sched.sv
// Directed + random bench for mux81_rr_sched against a
// channel-ownership reference model, with a mux81 on the outputs.
module tb_mux81_rr_sched;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [2:0] s;
    logic       e;
    logic [7:0] gnt;
    logic       busy;

    logic [7:0] i_cnt = 8'h00;
    logic       y;

    int vectors = 0;
    int miscompares = 0;

    // reference model: who owns the mux, how long, last served
    int   m_owner = -1;
    int   m_used  = 0;
    bit   m_gap   = 1'b0;
    int   m_last  = 7;
    int   m_s     = 0;

    int   order[$];
    logic prev_e = 1'b1;
    bit   track  = 1'b0;

    mux81_rr_sched #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .s    (s),
        .e    (e),
        .gnt  (gnt),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) i_cnt <= i_cnt + 8'd1;

    // behavioural mux81_enable fed by a free-running count
    assign y = e ? 1'b0 : i_cnt[s];

    function automatic int rr_find(logic [7:0] r, int last);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (last + k) % 8;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_owner = -1; m_used = 0; m_gap = 0;
            m_last = 7; m_s = 0;
        end else if (m_owner >= 0) begin
            if (m_used == HOLD || !req[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else begin
                m_used++;
            end
        end else begin
            w = rr_find(req, m_last);
            m_gap = 0;
            if (w >= 0) begin
                m_owner = w; m_last = w; m_s = w; m_used = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] x_gnt;
        logic       x_e;
        logic       x_y;
        x_e   = (m_owner < 0);
        x_gnt = x_e ? 8'h00 : (8'h01 << m_owner);
        x_y   = x_e ? 1'b0 : i_cnt[m_s];
        chk("s", {5'd0, s}, 8'(m_s));
        chk("e", {7'd0, e}, {7'd0, x_e});
        chk("gnt", gnt, x_gnt);
        chk("busy", {7'd0, busy}, {7'd0, (m_owner >= 0) || m_gap});
        chk("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
        chk("y", {7'd0, y}, {7'd0, x_y});
        if (track && prev_e === 1'b1 && e === 1'b0)
            order.push_back(int'(s));
        prev_e = e;
    endtask

    task automatic cyc(int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 2, 7, 0, 2};

        // reset
        rst = 1; req = 8'h00;
        cyc(2);

        // single requester: period HOLD+1
        rst = 0; req = 8'h01;
        cyc(16);

        // 0x85: order 0,2,7,0,2
        rst = 1; cyc(1);
        rst = 0; req = 8'h85; track = 1; order.delete();
        cyc(26);
        track = 0;
        chk("order_len", 8'(order.size() >= 5), 8'd1);
        for (int k = 0; k < 5; k++)
            if (k < order.size())
                chk("order", 8'(order[k]), 8'(exp_order[k]));

        // all requesting: s steps 0..7,0
        rst = 1; cyc(1);
        rst = 0; req = 8'hFF;
        cyc(46);

        // early release after 2 granted clocks, then idle
        rst = 1; cyc(1);
        rst = 0; req = 8'h08;
        cyc(2);
        req = 8'h00;
        cyc(4);

        // reset on 2nd grant clock, then restart from channel 0
        rst = 1; cyc(1);
        rst = 0; req = 8'h80;
        cyc(2);
        rst = 1;
        cyc(1);
        rst = 0; req = 8'h81;
        cyc(1);
        chk("first_after_rst", {5'd0, s}, 8'd0);
        cyc(10);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0)
                req = 8'($urandom);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
